// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, stall encodings and FSM state type for the pipeline control unit.
package pipe_ctrl_pkg;

  localparam logic FLUSH     = 1'b1;
  localparam logic EXCEPTION = 1'b1;
  localparam logic BRANCH    = 1'b0;

  localparam logic [3:0] STALL_NONE = 4'b0000;
  localparam logic [3:0] STALL_FE   = 4'b0001;
  localparam logic [3:0] STALL_EX   = 4'b0011;
  localparam logic [3:0] STALL_MEM  = 4'b0111;

  localparam logic [31:0] EXC_OFFSET_DEFAULT = 32'h0000_0180;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_EXC_PEND = 2'd1,
    ST_BR_PEND  = 2'd2
  } state_e;

  // Thermometer stall vector: the oldest stalled stage freezes everything younger.
  function automatic logic [3:0] stall_encode(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    if (req_mem)              return STALL_MEM;
    else if (req_ex)          return STALL_EX;
    else if (req_id || req_if) return STALL_FE;
    else                      return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector merge, branch/exception flush generation with
// pending hold while the owning stage is stalled, redirect PC and event counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_OFFSET = EXC_OFFSET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        excp_valid_i,
  input  logic        excp_is_eret_i,
  input  logic [31:0] cp0_epc_i,
  input  logic [31:0] cp0_ebase_i,
  input  logic        bpu_flush_i,
  input  logic [31:0] bpu_target_i,
  output logic [3:0]  stall_o,
  output logic        flush_o,
  output logic        flush_cause_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o
);

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [3:0]  stall_req;
  logic [31:0] exc_target;
  logic        br_blocked;

  assign stall_req  = stall_encode(stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
  assign exc_target = excp_is_eret_i ? cp0_epc_i : (cp0_ebase_i + EXC_OFFSET);
  assign br_blocked = stallreq_ex_i || stallreq_mem_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // An exception always outranks a branch, including one already pending.
  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      ST_EXC_PEND: begin
        if (!stallreq_mem_i) state_d = ST_RUN;
      end
      ST_RUN, ST_BR_PEND: begin
        if (excp_valid_i) begin
          if (stallreq_mem_i) begin
            state_d   = ST_EXC_PEND;
            pend_pc_d = exc_target;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_q == ST_BR_PEND) begin
          if (!br_blocked) state_d = ST_RUN;
        end else if (bpu_flush_i && br_blocked) begin
          state_d   = ST_BR_PEND;
          pend_pc_d = bpu_target_i;
        end
      end
      default: begin
        state_d   = ST_RUN;
        pend_pc_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_o       = stall_req;
    flush_o       = 1'b0;
    flush_cause_o = BRANCH;
    new_pc_o      = '0;
    if (!rst) begin
      stall_o = STALL_NONE;
    end else begin
      case (state_q)
        ST_EXC_PEND: begin
          stall_o = STALL_MEM;
          if (!stallreq_mem_i) begin
            stall_o       = STALL_NONE;
            flush_o       = FLUSH;
            flush_cause_o = EXCEPTION;
            new_pc_o      = pend_pc_q;
          end
        end
        ST_RUN, ST_BR_PEND: begin
          if (excp_valid_i) begin
            if (!stallreq_mem_i) begin
              stall_o       = STALL_NONE;
              flush_o       = FLUSH;
              flush_cause_o = EXCEPTION;
              new_pc_o      = exc_target;
            end
          end else if (!br_blocked && (state_q == ST_BR_PEND || bpu_flush_i)) begin
            stall_o       = {stall_req[3:1], 1'b0};
            flush_o       = FLUSH;
            flush_cause_o = BRANCH;
            new_pc_o      = (state_q == ST_BR_PEND) ? pend_pc_q : bpu_target_i;
          end
        end
        default: stall_o = STALL_NONE;
      endcase
    end
  end

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (stall_o != STALL_NONE),
    .count_o (stall_cycles_o)
  );

  sat_counter #(.WIDTH(16)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (flush_o),
    .count_o (flush_count_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// against a pending-event reference model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_if, s_id, s_ex, s_mem;
  logic        excp, eret, bpu;
  logic [31:0] epc, ebase, target;
  logic [3:0]  stall_o;
  logic        flush_o, flush_cause_o;
  logic [31:0] new_pc_o, stall_cycles_o;
  logic [15:0] flush_count_o;
  logic        sat_en = 1'b0;
  logic [2:0]  sat_cnt;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned e_stall = 0;
  int unsigned e_flush = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.EXC_OFFSET(32'h0000_0180)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(s_if), .stallreq_id_i(s_id), .stallreq_ex_i(s_ex), .stallreq_mem_i(s_mem),
    .excp_valid_i(excp), .excp_is_eret_i(eret), .cp0_epc_i(epc), .cp0_ebase_i(ebase),
    .bpu_flush_i(bpu), .bpu_target_i(target),
    .stall_o(stall_o), .flush_o(flush_o), .flush_cause_o(flush_cause_o), .new_pc_o(new_pc_o),
    .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
  );

  sat_counter #(.WIDTH(3)) u_sat (.clk(clk), .rst_n(rst), .en_i(sat_en), .count_o(sat_cnt));

  task automatic set_idle();
    s_if = 0; s_id = 0; s_ex = 0; s_mem = 0;
    excp = 0; eret = 0; bpu = 0;
    epc = '0; ebase = '0; target = '0;
  endtask

  // Close the current cycle, crediting the expected counter increments.
  task automatic next_cycle(input bit st_nz, input bit fl);
    @(posedge clk); #1;
    if (st_nz) e_stall++;
    if (fl) e_flush++;
  endtask

  task automatic test_reset();
    set_idle();
    s_mem = 1; excp = 1;
    #2;
    checks++; if (stall_o !== 4'b0000) begin failures++; $display("FAIL reset_stall got=%b exp=0000", stall_o); end
    checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush_o); end
    checks++; if (flush_cause_o !== 1'b0) begin failures++; $display("FAIL reset_cause got=%b exp=0", flush_cause_o); end
    checks++; if (new_pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", new_pc_o); end
    checks++; if (stall_cycles_o !== 32'h0 || flush_count_o !== 16'h0) begin failures++;
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles_o, flush_count_o); end
    set_idle();
    @(posedge clk); #1;
    rst = 1;
    e_stall = 0; e_flush = 0;
    next_cycle(0, 0);
  endtask

  task automatic test_stall_ex();
    set_idle();
    s_ex = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (stall_o !== 4'b0011) begin failures++; $display("FAIL stall_ex got=%b exp=0011", stall_o); end
      next_cycle(1, 0);
    end
    s_ex = 0;
    @(negedge clk);
    checks++; if (stall_o !== 4'b0000) begin failures++; $display("FAIL stall_ex_release got=%b exp=0000", stall_o); end
    checks++; if (stall_cycles_o !== 32'd3) begin failures++; $display("FAIL stall_cycles got=%0d exp=3", stall_cycles_o); end
    next_cycle(0, 0);
  endtask

  task automatic test_stall_priority();
    logic [3:0] exp_st;
    set_idle();
    for (int unsigned v = 0; v < 16; v++) begin
      {s_mem, s_ex, s_id, s_if} = v[3:0];
      exp_st = s_mem ? 4'b0111 : s_ex ? 4'b0011 : (s_id | s_if) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      checks++; if (stall_o !== exp_st) begin failures++; $display("FAIL stall_prio req=%b got=%b exp=%b", v[3:0], stall_o, exp_st); end
      next_cycle(exp_st != 0, 0);
    end
    set_idle();
  endtask

  task automatic test_exc_immediate();
    set_idle();
    excp = 1; ebase = 32'hBFC0_0000; epc = 32'h1111_2222;
    @(negedge clk);
    checks++; if (flush_o !== 1'b1 || flush_cause_o !== 1'b1) begin failures++;
      $display("FAIL exc_flush got=%b/%b exp=1/1", flush_o, flush_cause_o); end
    checks++; if (new_pc_o !== 32'hBFC0_0180) begin failures++; $display("FAIL exc_vector got=%h exp=bfc00180", new_pc_o); end
    checks++; if (stall_o !== 4'b0000) begin failures++; $display("FAIL exc_stall got=%b exp=0000", stall_o); end
    next_cycle(0, 1);
    eret = 1; epc = 32'h8000_2000; s_id = 1;
    @(negedge clk);
    checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h8000_2000) begin failures++;
      $display("FAIL b2b_eret got=%b/%h exp=1/80002000", flush_o, new_pc_o); end
    checks++; if (stall_o !== 4'b0000) begin failures++; $display("FAIL b2b_stall got=%b exp=0000", stall_o); end
    next_cycle(0, 1);
    set_idle();
    @(negedge clk);
    checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL exc_single_pulse got=%b exp=0", flush_o); end
    checks++; if (flush_count_o !== 16'(e_flush)) begin failures++; $display("FAIL exc_count got=%0d exp=%0d", flush_count_o, e_flush); end
    next_cycle(0, 0);
  endtask

  task automatic test_eret_pending();
    set_idle();
    excp = 1; eret = 1; epc = 32'h8000_1234; s_mem = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (stall_o !== 4'b0111 || flush_o !== 1'b0) begin failures++;
        $display("FAIL exc_pend_hold cyc=%0d got=%b/%b exp=0111/0", i, stall_o, flush_o); end
      next_cycle(1, 0);
      excp = 0; eret = 0; epc = 32'hDEAD_0000;
    end
    s_mem = 0; s_ex = 1;
    @(negedge clk);
    checks++; if (flush_o !== 1'b1 || flush_cause_o !== 1'b1) begin failures++;
      $display("FAIL exc_pend_flush got=%b/%b exp=1/1", flush_o, flush_cause_o); end
    checks++; if (new_pc_o !== 32'h8000_1234) begin failures++; $display("FAIL exc_pend_pc got=%h exp=80001234", new_pc_o); end
    checks++; if (stall_o !== 4'b0000) begin failures++; $display("FAIL exc_pend_stall got=%b exp=0000", stall_o); end
    next_cycle(0, 1);
    set_idle();
    @(negedge clk);
    checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL exc_pend_after got=%b exp=0", flush_o); end
    next_cycle(0, 0);
  endtask

  task automatic test_branch_pending();
    set_idle();
    bpu = 1; target = 32'h8000_0040; s_ex = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (flush_o !== 1'b0 || stall_o !== 4'b0011) begin failures++;
        $display("FAIL br_pend_hold cyc=%0d got=%b/%b exp=0/0011", i, flush_o, stall_o); end
      next_cycle(1, 0);
      bpu = 0; target = 32'h0BAD_0BAD;
    end
    s_ex = 0; s_if = 1;
    @(negedge clk);
    checks++; if (flush_o !== 1'b1 || flush_cause_o !== 1'b0) begin failures++;
      $display("FAIL br_pend_flush got=%b/%b exp=1/0", flush_o, flush_cause_o); end
    checks++; if (new_pc_o !== 32'h8000_0040) begin failures++; $display("FAIL br_pend_pc got=%h exp=80000040", new_pc_o); end
    checks++; if (stall_o !== 4'b0000) begin failures++; $display("FAIL br_fe_forced got=%b exp=0000", stall_o); end
    next_cycle(0, 1);
    set_idle();
    @(negedge clk);
    checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL br_pend_after got=%b exp=0", flush_o); end
    next_cycle(0, 0);
  endtask

  task automatic test_br_pend_exc_override();
    set_idle();
    bpu = 1; target = 32'h8000_0800; s_ex = 1;
    next_cycle(1, 0);
    bpu = 0; excp = 1; ebase = 32'hBFC0_0000;
    @(negedge clk);
    checks++; if (flush_o !== 1'b1 || flush_cause_o !== 1'b1 || new_pc_o !== 32'hBFC0_0180) begin failures++;
      $display("FAIL br_exc_override got=%b/%b/%h exp=1/1/bfc00180", flush_o, flush_cause_o, new_pc_o); end
    checks++; if (stall_o !== 4'b0000) begin failures++; $display("FAIL br_exc_stall got=%b exp=0000", stall_o); end
    next_cycle(0, 1);
    set_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL br_dropped cyc=%0d got=%b exp=0", i, flush_o); end
      next_cycle(0, 0);
    end
    @(negedge clk);
    checks++; if (flush_count_o !== 16'(e_flush)) begin failures++; $display("FAIL br_exc_count got=%0d exp=%0d", flush_count_o, e_flush); end
    checks++; if (stall_cycles_o !== e_stall) begin failures++; $display("FAIL br_exc_stallcnt got=%0d exp=%0d", stall_cycles_o, e_stall); end
    next_cycle(0, 0);
  endtask

  task automatic test_reset_mid_pend();
    set_idle();
    excp = 1; s_mem = 1; ebase = 32'h1234_0000;
    next_cycle(1, 0);
    excp = 0;
    @(negedge clk);
    checks++; if (stall_o !== 4'b0111) begin failures++; $display("FAIL rstpend_pre got=%b exp=0111", stall_o); end
    #1 rst = 0;
    #1;
    checks++; if (stall_o !== 4'b0000 || flush_o !== 1'b0 || flush_cause_o !== 1'b0 || new_pc_o !== 32'h0) begin failures++;
      $display("FAIL rstpend_outputs got=%b/%b/%b/%h exp=0000/0/0/0", stall_o, flush_o, flush_cause_o, new_pc_o); end
    checks++; if (stall_cycles_o !== 32'h0 || flush_count_o !== 16'h0) begin failures++;
      $display("FAIL rstpend_counters got=%0d/%0d exp=0/0", stall_cycles_o, flush_count_o); end
    @(posedge clk); #1;
    set_idle();
    rst = 1;
    e_stall = 0; e_flush = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL rstpend_noflush cyc=%0d got=%b exp=0", i, flush_o); end
      next_cycle(0, 0);
    end
  endtask

  // Model: at most one pending event (kind + PC); exceptions beat branches.
  task automatic test_random();
    int          pend_kind = 0;  // 0 none, 1 exception, 2 branch
    logic [31:0] pend_pc = '0;
    int          nxt_kind;
    logic [31:0] nxt_pc, exc_pc, e_pc;
    logic [3:0]  req_st, e_st;
    logic        e_fl, e_cause;
    for (int c = 0; c < 1500; c++) begin
      s_if = ($urandom_range(0, 9) < 3); s_id = ($urandom_range(0, 9) < 3);
      s_ex = ($urandom_range(0, 9) < 3); s_mem = ($urandom_range(0, 9) < 3);
      excp = ($urandom_range(0, 9) < 2); eret = $urandom_range(0, 1) == 1;
      bpu = ($urandom_range(0, 9) < 3);
      epc = $urandom; ebase = $urandom; target = $urandom;
      req_st = s_mem ? 4'd7 : s_ex ? 4'd3 : (s_if | s_id) ? 4'd1 : 4'd0;
      exc_pc = eret ? epc : ebase + 32'h180;
      e_st = req_st; e_fl = 0; e_cause = 0; e_pc = '0;
      nxt_kind = pend_kind; nxt_pc = pend_pc;
      if (pend_kind == 1) begin
        e_st = 4'd7;
        if (!s_mem) begin e_st = 0; e_fl = 1; e_cause = 1; e_pc = pend_pc; nxt_kind = 0; end
      end else if (excp) begin
        if (!s_mem) begin e_st = 0; e_fl = 1; e_cause = 1; e_pc = exc_pc; nxt_kind = 0; end
        else begin nxt_kind = 1; nxt_pc = exc_pc; end
      end else if (pend_kind == 2) begin
        if (!s_ex && !s_mem) begin e_st = req_st & 4'hE; e_fl = 1; e_pc = pend_pc; nxt_kind = 0; end
      end else if (bpu) begin
        if (!s_ex && !s_mem) begin e_st = req_st & 4'hE; e_fl = 1; e_pc = target; end
        else begin nxt_kind = 2; nxt_pc = target; end
      end
      @(negedge clk);
      checks++; if (stall_o !== e_st) begin failures++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall_o, e_st); end
      checks++; if (flush_o !== e_fl) begin failures++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, flush_o, e_fl); end
      if (e_fl) begin
        checks++; if (flush_cause_o !== e_cause || new_pc_o !== e_pc) begin failures++;
          $display("FAIL rnd_redirect c=%0d got=%b/%h exp=%b/%h", c, flush_cause_o, new_pc_o, e_cause, e_pc); end
      end
      checks++; if (stall_cycles_o !== e_stall || flush_count_o !== 16'(e_flush)) begin failures++;
        $display("FAIL rnd_counters c=%0d got=%0d/%0d exp=%0d/%0d", c, stall_cycles_o, flush_count_o, e_stall, e_flush); end
      next_cycle(e_st != 0, e_fl);
      pend_kind = nxt_kind; pend_pc = nxt_pc;
    end
    set_idle();
  endtask

  task automatic test_sat_counter();
    sat_en = 1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      checks++; if (sat_cnt !== 3'((i > 7) ? 7 : i)) begin failures++;
        $display("FAIL sat_counter step=%0d got=%0d exp=%0d", i, sat_cnt, (i > 7) ? 7 : i); end
    end
    sat_en = 0;
  endtask

  initial begin
    test_reset();
    test_stall_ex();
    test_stall_priority();
    test_exc_immediate();
    test_eret_pending();
    test_branch_pending();
    test_br_pend_exc_override();
    test_reset_mid_pend();
    test_random();
    test_sat_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the dual-issue core. It merges per-stage stall requests into the thermometer-coded `stall` vector, and generates `flush` / `flush_cause` for branch mispredicts from execute and for exceptions or `eret` committed in memory. It also produces the redirect PC. A flush that arrives while the owning stage is stalled is held pending until the stall releases. The block sits beside the pipeline registers (if_id, id_ex, ex_mem, mem_wb) and the PC unit, and drives their `stall` / `flush` / `flush_cause` inputs.

## Interface
- `EXC_OFFSET`, default 32'h0000_0180: offset added to `cp0_ebase_i` for the general exception vector.
- `clk`  in  1  core clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `stallreq_if_i`  in  1  fetch stall request (icache miss).
- `stallreq_id_i`  in  1  issue stall request (operand hazard).
- `stallreq_ex_i`  in  1  execute stall request (mul/div busy).
- `stallreq_mem_i`  in  1  memory stall request (dcache/uncached bus busy).
- `excp_valid_i`  in  1  exception committed in memory this cycle.
- `excp_is_eret_i`  in  1  committed event is `eret`; qualified by `excp_valid_i`.
- `cp0_epc_i`  in  32  current EPC.
- `cp0_ebase_i`  in  32  exception base.
- `bpu_flush_i`  in  1  branch mispredict resolved in execute.
- `bpu_target_i`  in  32  correct branch target.
- `stall_o`  out  4  stall vector. Bit 0 = front end, 1 = execute, 2 = memory, 3 = writeback.
- `flush_o`  out  1  flush pulse.
- `flush_cause_o`  out  1  `Exception` (1) or `Branch` (0).
- `new_pc_o`  out  32  redirect PC; valid while `flush_o` = 1.
- `stall_cycles_o`  out  32  saturating count of cycles with `stall_o != 0`.
- `flush_count_o`  out  16  saturating count of flush pulses.

## Operation

Reset values:
- `stall_o` = 0, `flush_o` = 0, `flush_cause_o` = `Branch`.
- `new_pc_o` = 0, both counters = 0.
- FSM = RUN, pending registers = 0.

Stall vector (combinational from requests), highest-priority request wins:
- mem → 4'b0111
- ex → 4'b0011
- id or if → 4'b0001
- none → 4'b0000
- `stall_o[3]` is always 0; writeback never stalls.

FSM states: RUN, EXC_PEND, BR_PEND.

RUN:
- `excp_valid_i` and not `stallreq_mem_i`:
  - `flush_o` = 1, `flush_cause_o` = `Exception`.
  - `new_pc_o` = `cp0_epc_i` if eret, else `cp0_ebase_i + EXC_OFFSET`.
  - `stall_o` forced to 0. Stay in RUN.
- `excp_valid_i` and `stallreq_mem_i`:
  - Latch target into `pend_pc`; go to EXC_PEND.
  - No flush this cycle; `stall_o` per requests.
- Otherwise, `bpu_flush_i` and not `stallreq_ex_i` and not `stallreq_mem_i`:
  - `flush_o` = 1, cause `Branch`, `new_pc_o` = `bpu_target_i`.
  - `stall_o[0]` forced 0; upper bits per requests.
- `bpu_flush_i` while ex or mem stalled: latch `bpu_target_i`; go to BR_PEND.

EXC_PEND:
- Hold `stall_o` = 4'b0111 regardless of requests.
- When `stallreq_mem_i` = 0: flush with cause `Exception`, `new_pc_o` = `pend_pc`, `stall_o` = 0; go to RUN.

BR_PEND:
- `excp_valid_i` overrides: it is handled exactly as in RUN (immediate flush, or EXC_PEND). The branch pending is discarded.
- When `stallreq_ex_i` = 0 and `stallreq_mem_i` = 0: Branch flush with `pend_pc`; go to RUN.

Simultaneous exception and branch in the same cycle: the exception wins and the branch is dropped.

Counters:
- +1 per qualifying cycle or pulse.
- Saturate at all-ones; no wrap.

## Timing
- Outputs are combinational from the FSM, pending registers and inputs, so a flush takes effect at the next `clk` edge in the same cycle as the event.
- `flush_o` is high exactly one cycle per event. Two events back-to-back produce two consecutive pulses.
- Pending latency: the flush appears in the first cycle in which the blocking stall request is low.
- Asynchronous reset mid-pending discards the pending event.
- Counters update on the clock edge after the qualifying cycle.

## Structure
- Shared package / `defines.v`:
  - `Flush`, `Exception`, `Branch` constants.
  - Stall vector encodings `STALL_NONE` / `STALL_FE` / `STALL_EX` / `STALL_MEM`.
  - FSM state encodings.
  - `EXC_OFFSET` default.
- One sub-module, `sat_counter` (parameterised width, enable, async active-low reset), instantiated twice.

## Test plan
- `stallreq_ex_i` = 1 for 3 cycles → `stall_o` = 4'b0011 for 3 cycles, `stall_cycles_o` = 3 afterwards.
- `excp_valid_i` = 1, `cp0_ebase_i` = 32'hBFC0_0000, no stall → same cycle: `flush_o` = 1, cause `Exception`, `new_pc_o` = 32'hBFC0_0180, `stall_o` = 0.
- `excp_valid_i` + `excp_is_eret_i`, `cp0_epc_i` = 32'h8000_1234, `stallreq_mem_i` high for 4 cycles → `stall_o` = 4'b0111 for 4 cycles, no flush; cycle 5: flush, `new_pc_o` = 32'h8000_1234.
- `bpu_flush_i`, `bpu_target_i` = 32'h8000_0040, `stallreq_ex_i` high for 2 cycles → BR_PEND; cycle 3: flush cause `Branch`, `new_pc_o` = 32'h8000_0040.
- In BR_PEND, `excp_valid_i` with no mem stall → Exception flush to the ebase vector; no later Branch flush; `flush_count_o` +1.
- `rst` asserted low while in EXC_PEND → all outputs 0 immediately; after release, no flush occurs.
